// File: rtl/inst_mem_resp.sv
// Instruction memory responder: a word-addressed instruction RAM with a
// programmable number of wait states, a one-cycle response pulse and a
// side-band loader write port.
module inst_mem_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] addr,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        addr_err,
  output logic        stall_req,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q;
  logic        err_q;
  logic        resp_en;
  logic [31:0] rd_addr;

  logic [31:0] mem_q [DEPTH];

  // A byte address is usable only if word-aligned and inside the array.
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:DEPTH_LOG2+2] == '0);
  endfunction

  // Next-state logic; rd_addr selects the live address when a request goes
  // straight to RESP (zero wait states), otherwise the captured one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    resp_en = 1'b0;
    rd_addr = addr_q;
    case (state_q)
      IDLE, RESP: begin
        if (ce) begin
          addr_d = addr;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            resp_en = 1'b1;
            rd_addr = addr;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(WAIT_CYCLES - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (ce) begin
          if (cnt_q == 3'd0) begin
            state_d = RESP;
            resp_en = 1'b1;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Control state and the registered response; reset clears all of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 32'h0;
      inst_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (resp_en) begin
        inst_q <= addr_ok(rd_addr) ? mem_q[rd_addr[DEPTH_LOG2+1:2]] : 32'h0;
        err_q  <= !addr_ok(rd_addr);
      end
    end
  end

  // Loader writes; no reset so contents survive and loads work during reset.
  // Non-blocking update gives read-before-write against a same-edge response.
  always_ff @(posedge clk) begin
    if (ld_we && addr_ok(ld_addr)) begin
      mem_q[ld_addr[DEPTH_LOG2+1:2]] <= ld_data;
    end
  end

  assign inst       = inst_q;
  assign addr_err   = err_q;
  assign inst_valid = (state_q == RESP);
  assign stall_req  = (state_q == WAIT);

endmodule

// File: doc/inst_mem_resp.md
INST_MEM_RESP -- requirements
Module: inst_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the instruction word count (1024 words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, legal range 0..7, meaning wait states inserted before each response.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high (`RstEnable).
REQ-005 SHALL have port ce  input  1  fetch request / instruction memory enable from the PC stage (`ChipEnable = 1).
REQ-006 SHALL have port addr  input  32  byte address of the requested instruction (`InstAddrBus).
REQ-007 SHALL have port inst  output  32  returned instruction word (`InstBus).
REQ-008 SHALL have port inst_valid  output  1  one-cycle pulse; inst is valid for this request.
REQ-009 SHALL have port addr_err  output  1  qualified by inst_valid; request was misaligned or out of range.
REQ-010 SHALL have port stall_req  output  1  high while a request is outstanding in WAIT; the fetch stage holds PC.
REQ-011 SHALL have port ld_we  input  1  loader write enable.
REQ-012 SHALL have port ld_addr  input  32  loader byte address.
REQ-013 SHALL have port ld_data  input  32  loader write data.

Function
REQ-014 SHALL use word index addr[DEPTH_LOG2+1:2] for reads and ld_addr[DEPTH_LOG2+1:2] for loads.
REQ-015 SHALL implement states IDLE, WAIT and RESP, plus a 3-bit wait counter.
REQ-016 In IDLE with ce=1, SHALL capture addr into addr_q and go to WAIT with counter=WAIT_CYCLES-1; if WAIT_CYCLES=0, SHALL go directly to RESP.
REQ-017 In IDLE with ce=0, SHALL remain in IDLE with no output change except inst_valid=0.
REQ-018 In WAIT with ce=1, SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 0.
REQ-019 In WAIT with ce=0, SHALL abort the request, return to IDLE next edge, and produce no inst_valid.
REQ-020 On the edge entering RESP, SHALL register inst = mem[addr_q] if in range and aligned, else 32'h00000000 (NOP).
REQ-021 On the same edge, SHALL register addr_err = (addr_q[1:0]!=0) or (addr_q[31:DEPTH_LOG2+2]!=0).
REQ-022 In RESP, SHALL assert inst_valid=1 for exactly one cycle.
REQ-023 Latency SHALL be: inst_valid high exactly WAIT_CYCLES+1 cycles after the edge sampling ce=1 in IDLE.
REQ-024 In RESP with ce=1, SHALL capture the new addr and proceed as from IDLE (back-to-back); with ce=0, SHALL go to IDLE.
REQ-025 With WAIT_CYCLES=0 and ce held high, SHALL give sustained throughput of one inst_valid per cycle.
REQ-026 stall_req SHALL equal (state==WAIT), decoded from registered state only.
REQ-027 inst and addr_err SHALL hold their last values after inst_valid drops, until the next RESP entry.
REQ-028 ld_we=1 SHALL write ld_data to mem at posedge, in any state.
REQ-029 Loads with misaligned or out-of-range ld_addr SHALL be ignored.
REQ-030 A load and a RESP-entry read of the same word on the same edge SHALL return the old data (read-before-write).
REQ-031 An addr change while in WAIT SHALL NOT affect the outstanding request; only addr_q is used.

Reset
REQ-032 rst=1 SHALL asynchronously force state=IDLE, counter=0, addr_q=0, inst=0, inst_valid=0, addr_err=0 and stall_req=0.
REQ-033 Memory contents SHALL NOT be reset; loads while rst=1 SHALL still be accepted.
REQ-034 Reset asserted mid-request SHALL discard the request; after release, no inst_valid SHALL occur until a new ce=1 is sampled.

Verification
REQ-035 SHALL verify: load mem[0..3]=32'h34011100+i; WAIT_CYCLES=1; ce=1 with addr=0,4,8,12 each held while stall_req=1 -> inst_valid every 2nd cycle, inst=32'h34011100..03, addr_err=0.
REQ-036 SHALL verify: WAIT_CYCLES=0; ce held high; addr incrementing by 4 each cycle -> inst_valid high continuously, inst following one cycle behind addr.
REQ-037 SHALL verify: addr=32'h00000006 -> inst=0, addr_err=1; addr=32'h00001000 (DEPTH_LOG2=10) -> inst=0, addr_err=1.
REQ-038 SHALL verify: WAIT_CYCLES=3; ce dropped during the second WAIT cycle -> no inst_valid; IDLE next edge; stall_req=0.
REQ-039 SHALL verify: rst pulsed asynchronously between clock edges during WAIT -> all outputs 0 immediately; a subsequent request completes normally.
REQ-040 SHALL verify: ld_we writes 32'hDEADBEEF to word 5 on the RESP-entry edge for addr=20 -> inst returns the old value; the next read of addr=20 returns 32'hDEADBEEF.
